// File: rtl/ethrecv_if.sv
// rtl/ethrecv_if.sv - ethrecv GMII, CRC generator, buffer and controller signal bundle
//
// Purpose: groups every non-clock/reset signal of the ethrecv receive channel.
//   slave  : receiver side (the ethrecv module)
//   master : environment side (PHY, CRC generator, buffer memory, controller)
// Signals:
//   rxena   controller -> rx   receive enable / acknowledge
//   rxdv    PHY -> rx          GMII receive data valid
//   rxer    PHY -> rx          GMII receive error
//   datain  PHY -> rx          GMII receive byte (also feeds the CRC generator)
//   crc     gen -> rx          running CRC
//   crcen   rx -> gen          CRC calculate enable
//   crcre   rx -> gen          CRC reset
//   rxbdata rx -> buffer       32-bit word
//   rxbaddr rx -> buffer       word address
//   rxbwe   rx -> buffer       write strobe
//   rxcntb  rx -> controller   stored byte count
//   crc_err rx -> controller   FCS mismatch
//   len_err rx -> controller   length / receive error
//   rxdone  rx -> controller   frame complete
interface ethrecv_if;
  logic        rxena;
  logic        rxdv;
  logic        rxer;
  logic [7:0]  datain;
  logic [31:0] crc;
  logic        crcen;
  logic        crcre;
  logic [31:0] rxbdata;
  logic [8:0]  rxbaddr;
  logic        rxbwe;
  logic [10:0] rxcntb;
  logic        crc_err;
  logic        len_err;
  logic        rxdone;

  modport master (
    output rxena, rxdv, rxer, datain, crc,
    input  crcen, crcre, rxbdata, rxbaddr, rxbwe, rxcntb, crc_err, len_err, rxdone
  );

  modport slave (
    input  rxena, rxdv, rxer, datain, crc,
    output crcen, crcre, rxbdata, rxbaddr, rxbwe, rxcntb, crc_err, len_err, rxdone
  );
endinterface

// File: rtl/ethrecv.sv
// rtl/ethrecv.sv - GMII receive channel: preamble/SFD strip, word packing, CRC and length check
//
// Purpose: strips 7x 0x55 + 0xD5, packs DA..FCS little-endian into 32-bit
// buffer words, drives the external CRC generator and reports byte count,
// crc_err and len_err through the rxena/rxdone handshake.
// Ports:
//   clk  GMII RXCLK, all state changes on its falling edge
//   clr  asynchronous active-high reset
//   bus  ethrecv_if.slave (rxena, rxdv, rxer, datain, crc in;
//        crcen, crcre, rxbdata, rxbaddr, rxbwe, rxcntb, crc_err, len_err, rxdone out)
// Optional feature macro: RXER_CHECK_EN (rxer during a frame sets len_err).
module ethrecv #(
  parameter int          MINLEN      = 64,
  parameter int          MAXLEN      = 1518,
  parameter logic [31:0] CRC_RESIDUE = 32'hC704DD7B
) (
  input  logic      clk,
  input  logic      clr,
  ethrecv_if.slave  bus
);

  localparam logic [10:0] MIN_CNT = 11'(MINLEN);
  localparam logic [10:0] MAX_CNT = 11'(MAXLEN);

  typedef enum logic [2:0] {IDLE, DROP, WAITSFD, RECVDATA, CHECK, WAITDONE} state_t;

  state_t      state, next_state;
  logic [10:0] count;
  logic [31:0] word;
  logic        rxer_hit;

`ifdef RXER_CHECK_EN
  assign rxer_hit = bus.rxer & bus.rxdv & ((state == WAITSFD) | (state == RECVDATA));
`else
  logic unused_rxer;
  assign unused_rxer = bus.rxer;
  assign rxer_hit    = 1'b0;
`endif

  always_ff @(negedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= next_state;
  end

  // crcen/crcre are combinational so the generator consumes the byte that is
  // on datain during the same clk in which the receiver stores it.
  always_comb begin
    next_state = state;
    bus.crcre  = 1'b0;
    bus.crcen  = 1'b0;
    bus.rxdone = 1'b0;
    case (state)
      IDLE: begin
        bus.crcre = 1'b1;
        if (bus.rxena) next_state = bus.rxdv ? DROP : WAITSFD;
      end
      DROP: begin
        bus.crcre = 1'b1;
        if (!bus.rxdv) next_state = IDLE;
      end
      WAITSFD: begin
        bus.crcre = 1'b1;
        if (bus.rxdv) begin
          if (bus.datain == 8'hD5)      next_state = RECVDATA;
          else if (bus.datain != 8'h55) next_state = DROP;
        end
      end
      RECVDATA: begin
        if (bus.rxdv) bus.crcen = (count < MAX_CNT);
        else          next_state = CHECK;
      end
      CHECK:    next_state = WAITDONE;
      WAITDONE: begin
        bus.rxdone = 1'b1;
        if (!bus.rxena) next_state = IDLE;
      end
      default:  next_state = IDLE;
    endcase
  end

  // The low two bits of the byte counter double as the lane index.
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      count       <= '0;
      word        <= '0;
      bus.rxbdata <= '0;
      bus.rxbaddr <= '0;
      bus.rxbwe   <= 1'b0;
      bus.rxcntb  <= '0;
      bus.crc_err <= 1'b0;
      bus.len_err <= 1'b0;
    end else begin
      bus.rxbwe <= 1'b0;
      if (bus.rxbwe) bus.rxbaddr <= bus.rxbaddr + 9'd1;
      if (rxer_hit)  bus.len_err <= 1'b1;
      case (state)
        IDLE: begin
          count       <= '0;
          word        <= '0;
          bus.rxbaddr <= '0;
          bus.rxcntb  <= '0;
          bus.crc_err <= 1'b0;
          bus.len_err <= 1'b0;
        end
        RECVDATA: begin
          if (bus.rxdv) begin
            if (count < MAX_CNT) begin
              count <= count + 11'd1;
              if (count[1:0] == 2'd3) begin
                bus.rxbdata <= {bus.datain, word[23:0]};
                bus.rxbwe   <= 1'b1;
                word        <= '0;
              end else begin
                word[{count[1:0], 3'b000} +: 8] <= bus.datain;
              end
            end else begin
              bus.len_err <= 1'b1;
            end
          end else if (count[1:0] != 2'd0) begin
            // Partial last word; lanes never written are still zero.
            bus.rxbdata <= word;
            bus.rxbwe   <= 1'b1;
          end
        end
        CHECK: begin
          bus.crc_err <= (bus.crc != CRC_RESIDUE);
          if (count < MIN_CNT) bus.len_err <= 1'b1;
          bus.rxcntb  <= count;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ethrecv.sv
// tb/tb_ethrecv.sv - self-checking bench for ethrecv
module tb_ethrecv;

  localparam int MAXLEN = 1518;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  ethrecv_if bus();
  ethrecv dut (.clk(clk), .clr(clr), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  frm[$];
  logic [8:0]  got_a[$];
  logic [31:0] got_d[$];

  // Reference CRC-32 (reflected, poly 0xEDB88320).
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'b0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[k] = v[31-k];
    return r;
  endfunction

  // External CRC generator; presents its register MSB-first.
  logic [31:0] gen_r;
  always @(negedge clk) begin
    if (bus.crcre)      gen_r <= 32'hFFFFFFFF;
    else if (bus.crcen) gen_r <= crc_upd(gen_r, bus.datain);
  end
  assign bus.crc = rev32(gen_r);

  always @(posedge clk) begin
    if (bus.rxbwe) begin
      got_a.push_back(bus.rxbaddr);
      got_d.push_back(bus.rxbdata);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic build(input int len, input bit good, input bit flip, input int last);
    logic [31:0] c;
    frm.delete();
    if (good) begin
      for (int i = 0; i < len - 4; i++) frm.push_back(8'($urandom));
      c = 32'hFFFFFFFF;
      foreach (frm[i]) c = crc_upd(c, frm[i]);
      c = ~c;
      for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
    end else begin
      for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
    end
    if (flip) frm[10] = frm[10] ^ 8'h04;
    if (last >= 0) frm[len-1] = 8'(last);
  endtask

  function automatic logic [31:0] exp_word(input int k, input int n);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++)
      if (4*k + j < n) w = w | (32'(frm[4*k + j]) << (8*j));
    return w;
  endfunction

  // Sends preamble+SFD+frm, then checks handshake, results and buffer writes.
  // Leaves rxena=0 and the receiver in IDLE.
  task automatic run_frame(input string nm, input int writes, input int cnt, input bit ecrc,
                           input bit elen, input int rxer_idx, input int drop_idx);
    int lat;
    int n;
    got_a.delete();
    got_d.delete();
    @(posedge clk);
    bus.rxena = 1'b1;
    bus.rxdv  = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rxdv   = 1'b1;
      bus.datain = (i < 7) ? 8'h55 : 8'hD5;
      @(posedge clk);
    end
    foreach (frm[i]) begin
      bus.datain = frm[i];
      bus.rxer   = (i == rxer_idx);
      if (i == drop_idx) bus.rxena = 1'b0;
      @(posedge clk);
    end
    bus.rxdv   = 1'b0;
    bus.rxer   = 1'b0;
    bus.datain = 8'h00;
    lat = 0;
    while (!bus.rxdone && lat < 20) begin
      @(posedge clk);
      lat++;
    end
    chk({nm, " rxdone latency"}, lat, 2);
    chk({nm, " rxcntb"}, 32'(bus.rxcntb), cnt);
    chk({nm, " crc_err"}, 32'(bus.crc_err), 32'(ecrc));
    chk({nm, " len_err"}, 32'(bus.len_err), 32'(elen));
    n = (frm.size() < MAXLEN) ? frm.size() : MAXLEN;
    chk({nm, " write count"}, got_a.size(), writes);
    for (int i = 0; i < got_a.size() && i < writes; i++) begin
      chk($sformatf("%s addr[%0d]", nm, i), 32'(got_a[i]), i);
      chk($sformatf("%s data[%0d]", nm, i), got_d[i], exp_word(i, n));
    end
    if (drop_idx < 0) begin
      repeat (3) @(posedge clk);
      chk({nm, " rxdone held"}, 32'(bus.rxdone), 1);
      bus.rxena = 1'b0;
    end
    @(posedge clk);
    chk({nm, " rxdone cleared"}, 32'(bus.rxdone), 0);
  endtask

  typedef struct {
    int len;
    bit good;
    bit flip;
    int last;
    int writes;
    int cnt;
    bit ecrc;
    bit elen;
  } vec_t;

  vec_t vt[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    bus.rxena  = 1'b0;
    bus.rxdv   = 1'b0;
    bus.rxer   = 1'b0;
    bus.datain = 8'h00;

    vt[0] = '{64,   1'b1, 1'b0, -1,    16,  64,   1'b0, 1'b0};
    vt[1] = '{65,   1'b0, 1'b0, 'hA5,  17,  65,   1'b1, 1'b0};
    vt[2] = '{64,   1'b1, 1'b1, -1,    16,  64,   1'b1, 1'b0};
    vt[3] = '{40,   1'b1, 1'b0, -1,    10,  40,   1'b0, 1'b1};
    vt[4] = '{1600, 1'b0, 1'b0, -1,    380, 1518, 1'b1, 1'b1};
    vt[5] = '{0,    1'b0, 1'b0, -1,    0,   0,    1'b1, 1'b1};
    vt[6] = '{66,   1'b1, 1'b0, -1,    17,  66,   1'b0, 1'b0};
    vt[7] = '{1518, 1'b1, 1'b0, -1,    380, 1518, 1'b0, 1'b0};

    #23;
    chk("reset crcre",   32'(bus.crcre),   1);
    chk("reset rxdone",  32'(bus.rxdone),  0);
    chk("reset rxbaddr", 32'(bus.rxbaddr), 0);
    chk("reset rxcntb",  32'(bus.rxcntb),  0);
    chk("reset rxbwe",   32'(bus.rxbwe),   0);
    chk("reset crcen",   32'(bus.crcen),   0);
    chk("reset crc_err", 32'(bus.crc_err), 0);
    chk("reset len_err", 32'(bus.len_err), 0);
    chk("reset rxbdata", bus.rxbdata,      0);
    @(posedge clk);
    clr = 1'b0;

    for (int v = 0; v < 8; v++) begin
      build(vt[v].len, vt[v].good, vt[v].flip, vt[v].last);
      run_frame($sformatf("vec%0d", v), vt[v].writes, vt[v].cnt, vt[v].ecrc, vt[v].elen, -1, -1);
    end

    for (int r = 0; r < 5; r++) begin
      int len;
      bit fl;
      len = $urandom_range(56, 130);
      fl  = 1'($urandom_range(0, 1));
      build(len, 1'b1, fl, -1);
      run_frame($sformatf("rand%0d", r), (len + 3) / 4, len, fl, (len < 64), -1, -1);
    end

    // rxena dropped mid-frame: frame completes, rxdone is a one-clk pulse.
    build(64, 1'b1, 1'b0, -1);
    run_frame("ena_drop", 16, 64, 1'b0, 1'b0, -1, 30);

    // Controller enables while a frame is already on the wire.
    got_a.delete();
    got_d.delete();
    seen = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      bus.rxdv   = 1'b1;
      bus.datain = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : 8'($urandom);
      if (i == 12) bus.rxena = 1'b1;
      @(posedge clk);
      seen = seen | bus.rxdone;
    end
    bus.rxdv = 1'b0;
    repeat (10) begin
      @(posedge clk);
      seen = seen | bus.rxdone;
    end
    chk("join writes", got_a.size(), 0);
    chk("join rxdone", 32'(seen), 0);
    bus.rxena = 1'b0;
    build(64, 1'b1, 1'b0, -1);
    run_frame("after_join", 16, 64, 1'b0, 1'b0, -1, -1);

    // Asynchronous reset in the middle of a frame.
    @(posedge clk);
    bus.rxena = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 28; i++) begin
      bus.rxdv   = 1'b1;
      bus.datain = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : 8'($urandom);
      @(posedge clk);
    end
    chk("pre-clr crcen", 32'(bus.crcen), 1);
    #2 clr = 1'b1;
    #1;
    chk("clr crcen",   32'(bus.crcen),   0);
    chk("clr crcre",   32'(bus.crcre),   1);
    chk("clr rxbaddr", 32'(bus.rxbaddr), 0);
    chk("clr rxbwe",   32'(bus.rxbwe),   0);
    chk("clr rxbdata", bus.rxbdata,      0);
    @(posedge clk);
    clr = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk);
      seen = seen | bus.rxdone;
    end
    bus.rxdv = 1'b0;
    repeat (6) begin
      @(posedge clk);
      seen = seen | bus.rxdone;
    end
    chk("clr no rxdone", 32'(seen), 0);
    bus.rxena = 1'b0;
    build(64, 1'b1, 1'b0, -1);
    run_frame("after_clr", 16, 64, 1'b0, 1'b0, -1, -1);

    // rxer pulse inside an otherwise good frame.
    build(64, 1'b1, 1'b0, -1);
`ifdef RXER_CHECK_EN
    run_frame("rxer", 16, 64, 1'b0, 1'b1, 20, -1);
`else
    run_frame("rxer", 16, 64, 1'b0, 1'b0, 20, -1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ethrecv.md
Name: ethrecv

Overview:
- Receive channel of the RTL8211EG-based Ethernet controller; counterpart of the frame transmit module.
- Takes GMII receive bytes and strips the 7x 0x55 preamble and the 0xD5 SFD.
- Packs the frame, including the 4-byte FCS, little-endian into 32-bit words of the receive buffer memory.
- Drives the shared external CRC generator and reports byte count, CRC error and length error to the controller through an rxena/rxdone handshake.

Parameters:
- MINLEN, 64, minimum legal frame length in bytes (DA through FCS); shorter sets len_err.
- MAXLEN, 1518, maximum stored bytes (must be <= 2047); further bytes are discarded and set len_err.
- CRC_RESIDUE, 32'hC704DD7B, expected raw crc value after DA..FCS has been fed to the generator.

Ports:
- clk  in  1  receive clock (GMII RXCLK); all logic on its negative edge
- clr  in  1  reset, asynchronous, active-high
- rxena  in  1  receive enable / acknowledge from controller
- rxdv  in  1  GMII receive data valid
- rxer  in  1  GMII receive error
- datain  in  8  GMII receive data
- crc  in  32  running CRC from external generator
- crcen  out  1  CRC calculate enable (datain fed to generator while high)
- crcre  out  1  CRC reset
- rxbdata  out  32  word to buffer memory
- rxbaddr  out  9  buffer word address
- rxbwe  out  1  buffer write strobe, one clk per word
- rxcntb  out  11  bytes stored in frame (DA..FCS), valid while rxdone=1
- crc_err  out  1  FCS mismatch, valid while rxdone=1
- len_err  out  1  runt/oversize (or rxer, see feature), valid while rxdone=1
- rxdone  out  1  frame complete

Behaviour:
- Reset (async, immediate): state IDLE. Outputs: crcre=1, rxdone=0, rxbaddr=0, rxcntb=0, rxbwe=0, crcen=0, crc_err=0, len_err=0, rxbdata=0.
- IDLE:
  - Holds crcre=1, rxbaddr=0, byte counter=0, lane=0, error flags cleared.
  - rxena=1 & rxdv=0 -> WAITSFD.
  - rxena=1 & rxdv=1 (joined mid-frame) -> DROP.
- DROP: wait for rxdv=0 -> IDLE. Nothing written, rxdone stays 0.
- WAITSFD:
  - rxdv=1 & datain=0x55: stay.
  - rxdv=1 & datain=0xD5: release crcre, -> RECVDATA.
  - rxdv=1 & any other byte: -> DROP.
  - rxdv=0: stay.
- RECVDATA, each clk with rxdv=1:
  - Byte goes to lane (0:[7:0] .. 3:[31:24]); crcen=1 for that byte; counter increments.
  - When lane 3 is filled, or the partial word at frame end, rxbwe pulses one clk with the full word on rxbdata at the current rxbaddr.
  - rxbaddr increments in the clk after the write.
  - Unfilled lanes of a partial word are 0.
  - Once the counter reaches MAXLEN: no more writes, counter saturates, len_err=1.
  - rxdv=0: flush any partial word (one rxbwe), crcen=0, -> CHECK.
- CHECK, one clk:
  - crc_err = (crc != CRC_RESIDUE).
  - len_err |= (count < MINLEN).
  - rxcntb = count; rxdone=1 -> WAITDONE.
- WAITDONE:
  - Flags and rxcntb held.
  - rxdv activity ignored; a frame arriving here is dropped.
  - rxena=0: rxdone=0 -> IDLE. If rxdv=1 at that point, IDLE then goes to DROP as above.
- rxena dropped during WAITSFD/RECVDATA: frame is completed normally (CHECK, rxdone pulse). The next WAITDONE exits immediately since rxena=0; rxdone is high for one clk.
- Latency: rxdone rises 2 clk after the first rxdv=0 clk (flush write, then CHECK).
- Zero-byte frame (SFD then rxdv=0): no write, rxcntb=0, len_err=1, crc_err per compare.
- Address: 9-bit, never wraps at MAXLEN<=2047.

Optional Feature:
- RXER_CHECK_EN.
- Defined: rxer=1 on any clk with rxdv=1 in WAITSFD/RECVDATA sets len_err (frame still completes, rxdone raised).
- Undefined: rxer ignored entirely.

Test Plan:
- 64-byte frame (DA..FCS) with correct FCS after 7x0x55+0xD5 -> 16 rxbwe at addr 0..15, rxcntb=64, crc_err=0, len_err=0, rxdone until rxena=0.
- 65-byte frame, byte 64 = 0xA5 -> 17 writes, word 16 = 32'h000000A5, rxcntb=65.
- Same 64-byte frame with one payload bit flipped -> crc_err=1, len_err=0, rxcntb=64.
- 40-byte frame -> len_err=1, rxcntb=40, 10 writes; 1600-byte frame with MAXLEN=1518 -> rxcntb=1518, len_err=1, last addr 379 (words 0..379).
- rxena raised while rxdv=1 mid-frame -> no writes, no rxdone; next complete frame received normally at addr 0.
- clr pulsed mid-RECVDATA -> outputs at reset values immediately; with RXER_CHECK_EN, rxer pulse mid-frame -> len_err=1.
